// File: rtl/systolic_tile_sched.sv
// Tile scheduler for the NxN systolic MAC array: walks the output tiles of
// C = A x B in row-major order, handshaking start/calc_done/clear/dout_done
// with the array for each tile and advancing buffer addresses incrementally.
module systolic_tile_sched #(
  parameter int unsigned N       = 8,
  parameter int unsigned TW      = 8,
  parameter int unsigned AW      = 13,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_k,
  input  logic [TW-1:0] cmd_mt,
  input  logic [TW-1:0] cmd_pt,
  input  logic          cmd_out_mode,
  input  logic [AW-1:0] cmd_a_base,
  input  logic [AW-1:0] cmd_b_base,
  input  logic [AW-1:0] cmd_c_base,
  output logic          sa_start,
  output logic          sa_clear,
  output logic [7:0]    sa_k_param,
  output logic          sa_out_mode,
  input  logic          sa_calc_done,
  input  logic          sa_dout_done,
  output logic [AW-1:0] a_base,
  output logic [AW-1:0] b_base,
  output logic [AW-1:0] c_base,
  output logic [TW-1:0] tile_m,
  output logic [TW-1:0] tile_p,
  output logic          busy,
  output logic          job_done,
  output logic          err
);

  // Wait counter only needs to reach TIMEOUT-1: a wait state is abandoned
  // after TIMEOUT cycles spent in it without the awaited pulse.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_CALC, S_CLEAR, S_WAIT_DOUT, S_NEXT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    k_q, k_d;
  logic [TW-1:0] mt_q, mt_d, pt_q, pt_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] b_base0_q, b_base0_d;
  logic [AW-1:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
  logic [TW-1:0] tile_m_q, tile_m_d, tile_p_q, tile_p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          sa_start_q, sa_start_d, sa_clear_q, sa_clear_d;
  logic          cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic          job_done_q, job_done_d;
  logic          last_p, last_tile, degenerate;

  assign last_p     = (tile_p_q == pt_q - TW'(1));
  assign last_tile  = last_p && (tile_m_q == mt_q - TW'(1));
  assign degenerate = (cmd_k == 8'd0) || (cmd_mt == '0) || (cmd_pt == '0);

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    mt_d      = mt_q;
    pt_d      = pt_q;
    mode_d    = mode_q;
    b_base0_d = b_base0_q;
    a_base_d  = a_base_q;
    b_base_d  = b_base_q;
    c_base_d  = c_base_q;
    tile_m_d  = tile_m_q;
    tile_p_d  = tile_p_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          k_d       = cmd_k;
          mt_d      = cmd_mt;
          pt_d      = cmd_pt;
          mode_d    = cmd_out_mode;
          b_base0_d = cmd_b_base;
          a_base_d  = cmd_a_base;
          b_base_d  = cmd_b_base;
          c_base_d  = cmd_c_base;
          tile_m_d  = '0;
          tile_p_d  = '0;
          err_d     = 1'b0;
          state_d   = degenerate ? S_DONE : S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_CALC;
      end
      S_WAIT_CALC: begin
        if (sa_calc_done) begin
          state_d = S_CLEAR;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_WAIT_DOUT;
      end
      S_WAIT_DOUT: begin
        if (sa_dout_done) begin
          state_d = last_tile ? S_DONE : S_NEXT;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_NEXT: begin
        c_base_d = c_base_q + AW'(N);
        if (!last_p) begin
          tile_p_d = tile_p_q + TW'(1);
          b_base_d = b_base_q + AW'(k_q);
        end else begin
          tile_p_d = '0;
          b_base_d = b_base0_q;
          tile_m_d = tile_m_q + TW'(1);
          a_base_d = a_base_q + AW'(k_q);
        end
        state_d = S_START;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Pulses and status track the state being entered; job_done lags DONE.
    sa_start_d  = (state_d == S_START);
    sa_clear_d  = (state_d == S_CLEAR);
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    job_done_d  = (state_q == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      mt_q        <= '0;
      pt_q        <= '0;
      mode_q      <= 1'b0;
      b_base0_q   <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      c_base_q    <= '0;
      tile_m_q    <= '0;
      tile_p_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      sa_start_q  <= 1'b0;
      sa_clear_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      job_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      mt_q        <= mt_d;
      pt_q        <= pt_d;
      mode_q      <= mode_d;
      b_base0_q   <= b_base0_d;
      a_base_q    <= a_base_d;
      b_base_q    <= b_base_d;
      c_base_q    <= c_base_d;
      tile_m_q    <= tile_m_d;
      tile_p_q    <= tile_p_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      sa_start_q  <= sa_start_d;
      sa_clear_q  <= sa_clear_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      job_done_q  <= job_done_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign sa_start    = sa_start_q;
  assign sa_clear    = sa_clear_q;
  assign sa_k_param  = k_q;
  assign sa_out_mode = mode_q;
  assign a_base      = a_base_q;
  assign b_base      = b_base_q;
  assign c_base      = c_base_q;
  assign tile_m      = tile_m_q;
  assign tile_p      = tile_p_q;
  assign busy        = busy_q;
  assign job_done    = job_done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Scoreboard bench for systolic_tile_sched: a responder plays the array,
// a monitor checks every start/done against queued expectations.
module tb_systolic_tile_sched;

  localparam int N = 8, TW = 8, AW = 13, TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_out_mode = 1'b0;
  logic [7:0] cmd_k = '0;
  logic [TW-1:0] cmd_mt = '0, cmd_pt = '0;
  logic [AW-1:0] cmd_a_base = '0, cmd_b_base = '0, cmd_c_base = '0;
  logic sa_start, sa_clear, sa_out_mode, sa_calc_done, sa_dout_done;
  logic [7:0] sa_k_param;
  logic [AW-1:0] a_base, b_base, c_base;
  logic [TW-1:0] tile_m, tile_p;
  logic busy, job_done, err;

  systolic_tile_sched dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_k(cmd_k), .cmd_mt(cmd_mt), .cmd_pt(cmd_pt), .cmd_out_mode(cmd_out_mode),
    .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base), .cmd_c_base(cmd_c_base),
    .sa_start(sa_start), .sa_clear(sa_clear), .sa_k_param(sa_k_param),
    .sa_out_mode(sa_out_mode), .sa_calc_done(sa_calc_done), .sa_dout_done(sa_dout_done),
    .a_base(a_base), .b_base(b_base), .c_base(c_base), .tile_m(tile_m), .tile_p(tile_p),
    .busy(busy), .job_done(job_done), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] a, b, c;
    logic [TW-1:0] tm, tp;
    logic [7:0]    k;
    logic          mode;
  } tile_t;

  tile_t exp_q[$];
  bit    jd_q[$];

  int checks = 0, failures = 0;
  int calc_lat = 5, dout_lat = 8;
  int calc_cnt = 0, dout_cnt = 0;
  bit inj_req = 0, calc_seen = 0, dout_pending = 0;
  int n_starts = 0, n_clears = 0, n_done = 0;
  longint first_start_cyc = -1, last_clear_cyc = 0, last_dout_cyc = 0, done_cyc = 0;
  longint accept_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Array stand-in: calc_done calc_lat cycles after start, dout_done
  // dout_lat cycles after clear (0 = withheld), plus injected stray pulses.
  initial begin
    bit c_p, d_p;
    sa_calc_done = 1'b0;
    sa_dout_done = 1'b0;
    forever begin
      @(negedge clk);
      c_p = 0;
      d_p = 0;
      if (!rst_n) begin
        calc_cnt = 0;
        dout_cnt = 0;
      end else begin
        if (calc_cnt > 0) begin calc_cnt--; if (calc_cnt == 0) c_p = 1; end
        if (dout_cnt > 0) begin dout_cnt--; if (dout_cnt == 0) d_p = 1; end
        if (sa_start) calc_cnt = calc_lat;
        if (sa_clear) dout_cnt = dout_lat;
      end
      if (c_p) calc_seen = 1;
      if (d_p) begin last_dout_cyc = cyc; dout_pending = 0; end
      sa_calc_done = c_p | inj_req;
      inj_req = 0;
      sa_dout_done = d_p;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a start or job_done.
  initial begin
    tile_t e;
    bit ej;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("ready_vs_busy", cmd_ready, !busy);
        if (sa_start) begin
          n_starts++;
          if (first_start_cyc < 0) first_start_cyc = cyc;
          chk("start_while_drain", dout_pending, 0);
          calc_seen = 0;
          if (exp_q.size() == 0) begin
            failures++; checks++;
            $display("FAIL unexpected_start actual=start required=none");
          end else begin
            e = exp_q.pop_front();
            chk("a_base", a_base, e.a);
            chk("b_base", b_base, e.b);
            chk("c_base", c_base, e.c);
            chk("tile_m", tile_m, e.tm);
            chk("tile_p", tile_p, e.tp);
            chk("k_param", sa_k_param, e.k);
            chk("out_mode", sa_out_mode, e.mode);
          end
        end
        if (sa_clear) begin
          n_clears++;
          last_clear_cyc = cyc;
          chk("clear_after_calc", calc_seen, 1);
          dout_pending = 1;
        end
        if (job_done) begin
          n_done++;
          done_cyc = cyc;
          if (jd_q.size() == 0) begin
            failures++; checks++;
            $display("FAIL unexpected_job_done actual=pulse required=none");
          end else begin
            ej = jd_q.pop_front();
            chk("err_at_done", err, ej);
          end
        end
      end
    end
  end

  // Issue one job; nexp tiles are expected to start before it ends.
  task automatic issue(input int k, input int mt, input int pt, input bit mode,
                       input int a, input int b, input int c,
                       input int nexp, input bit experr);
    tile_t t;
    int n = 0, w = 0;
    while (!cmd_ready && w < 5000) begin @(negedge clk); w++; end
    if (!cmd_ready) begin
      failures++; checks++;
      $display("FAIL ready_wait actual=0 required=1");
    end
    n_starts = 0; n_clears = 0; first_start_cyc = -1;
    dout_pending = 0;
    for (int im = 0; im < mt; im++)
      for (int ip = 0; ip < pt; ip++) begin
        if (n < nexp) begin
          t.a = AW'(a + im * k);
          t.b = AW'(b + ip * k);
          t.c = AW'(c + (im * pt + ip) * N);
          t.tm = TW'(im); t.tp = TW'(ip);
          t.k = 8'(k); t.mode = mode;
          exp_q.push_back(t);
        end
        n++;
      end
    jd_q.push_back(experr);
    cmd_k = 8'(k); cmd_mt = TW'(mt); cmd_pt = TW'(pt); cmd_out_mode = mode;
    cmd_a_base = AW'(a); cmd_b_base = AW'(b); cmd_c_base = AW'(c);
    cmd_valid = 1'b1;
    @(negedge clk);
    accept_cyc = cyc;
    cmd_valid = 1'b0;
    cmd_k = 8'($urandom); cmd_mt = TW'($urandom); cmd_pt = TW'($urandom);
  endtask

  task automatic wait_done(input int target, input string name);
    int w = 0;
    while (n_done < target && w < 20000) begin @(negedge clk); w++; end
    if (n_done < target) begin
      failures++; checks++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, n_done, target);
    end
    @(negedge clk);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int k, mt, pt, w;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_err", err, 0);
    chk("idle_start", sa_start, 0);
    chk("idle_abase", a_base, 0);

    // Stray calc_done while idle must not start anything.
    inj_req = 1;
    repeat (4) @(negedge clk);
    chk("idle_spurious_busy", busy, 0);
    chk("idle_spurious_starts", n_starts, 0);

    // Single tile.
    issue(4, 1, 1, 1'b0, 0, 100, 200, 1, 1'b0);
    wait_done(1, "single");
    chk("single_starts", n_starts, 1);
    chk("single_clears", n_clears, 1);
    chk("single_start_cyc", first_start_cyc, accept_cyc);
    chk("single_done_cyc", done_cyc, last_dout_cyc + 2);

    // 2x3 tiles with a stray calc_done while the first tile drains.
    issue(16, 2, 3, 1'b1, 0, 100, 200, 6, 1'b0);
    w = 0;
    while (n_clears < 1 && w < 100) begin @(negedge clk); w++; end
    inj_req = 1;
    wait_done(2, "grid");
    chk("grid_starts", n_starts, 6);
    chk("grid_clears", n_clears, 6);

    // Degenerate commands finish without array activity.
    issue(0, 2, 2, 1'b0, 5, 6, 7, 0, 1'b0);
    wait_done(3, "k0");
    chk("k0_starts", n_starts, 0);
    chk("k0_done_cyc", done_cyc, accept_cyc + 1);
    issue(3, 0, 2, 1'b0, 5, 6, 7, 0, 1'b0);
    wait_done(4, "mt0");
    chk("mt0_starts", n_starts, 0);
    issue(3, 2, 0, 1'b0, 5, 6, 7, 0, 1'b0);
    wait_done(5, "pt0");
    chk("pt0_starts", n_starts, 0);

    // calc_done withheld: timeout.
    calc_lat = 0;
    issue(3, 2, 2, 1'b0, 10, 20, 30, 1, 1'b1);
    wait_done(6, "tmo_calc");
    chk("tmo_calc_clears", n_clears, 0);
    chk("tmo_calc_done_cyc", done_cyc, first_start_cyc + TIMEOUT + 2);
    chk("tmo_err_held", err, 1);

    // calc_done on the last allowed wait cycle wins; acceptance clears err.
    calc_lat = TIMEOUT;
    issue(2, 1, 1, 1'b1, 1, 2, 3, 1, 1'b0);
    chk("err_cleared", err, 0);
    wait_done(7, "tmo_edge");
    chk("tmo_edge_clears", n_clears, 1);

    // dout_done one cycle too late: drain timeout, late pulse ignored.
    calc_lat = 3; dout_lat = TIMEOUT + 1;
    issue(2, 1, 2, 1'b0, 1, 2, 3, 1, 1'b1);
    wait_done(8, "tmo_dout");
    chk("tmo_dout_done_cyc", done_cyc, last_clear_cyc + TIMEOUT + 2);
    repeat (4) @(negedge clk);
    chk("tmo_dout_idle", busy, 0);

    // Reset during the third tile's drain, then a fresh job.
    calc_lat = 4; dout_lat = 10;
    issue(16, 2, 3, 1'b0, 0, 100, 200, 6, 1'b0);
    w = 0;
    while (n_clears < 3 && w < 200) begin @(negedge clk); w++; end
    chk("rst_reach_tile2", n_clears, 3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tile_p", tile_p, 0);
    chk("mid_rst_cbase", c_base, 0);
    chk("mid_rst_kparam", sa_k_param, 0);
    chk("mid_rst_done", job_done, 0);
    exp_q.delete();
    jd_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_starts", n_starts, 3);
    issue(5, 2, 2, 1'b1, 40, 50, 60, 4, 1'b0);
    wait_done(9, "post_rst");
    chk("post_rst_job_starts", n_starts, 4);

    // Randomized jobs, issued back to back.
    for (int j = 0; j < 8; j++) begin
      k = $urandom_range(40, 1); mt = $urandom_range(3, 1); pt = $urandom_range(3, 1);
      calc_lat = $urandom_range(12, 1); dout_lat = $urandom_range(12, 1);
      issue(k, mt, pt, 1'($urandom), $urandom_range(8191), $urandom_range(8191),
            $urandom_range(8191), mt * pt, 1'b0);
      wait_done(10 + j, "rand");
      chk("rand_clears", n_clears, mt * pt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
